// File: rtl/alu_result_stage_simd_pkg.sv
// Shared definitions for the SIMD ALU result stage: lane geometry, SIMD
// mode encoding and the auto-reset selector values.
package pirdsp_alu_pkg;

  typedef enum logic {
    mode_16x16   = 1'b0,
    mode_sum_8x8 = 1'b1
  } simd_mode_e;

  localparam int AR_NONE    = 0;
  localparam int AR_MATCH   = 1;
  localparam int AR_NOMATCH = 2;

  localparam int LANE_WIDTH = 16;
  localparam int LANE_COUNT = 2;

endpackage

// File: rtl/alu_result_stage_simd_if.sv
// Bus between the SIMD ALU side (master) and the result stage (slave).
// ACC_COUNT only exists when ALU_RESULT_ACC_COUNT_EN is defined.
interface alu_result_stage_simd_if;

  logic        CEP;
  logic        RSTP;
  logic        USE_SIMD;
  logic [31:0] S;
  logic [1:0]  result_SIMD_carry_out;
  logic [31:0] P;
  logic [1:0]  CARRYOUT;
  logic [1:0]  PATTERNDETECT;
  logic [1:0]  PATTERNBDETECT;
  logic [1:0]  OVERFLOW;
  logic [1:0]  UNDERFLOW;
`ifdef ALU_RESULT_ACC_COUNT_EN
  logic [7:0]  ACC_COUNT;
`endif

  modport master (
    output CEP, RSTP, USE_SIMD, S, result_SIMD_carry_out,
    input  P, CARRYOUT, PATTERNDETECT, PATTERNBDETECT, OVERFLOW, UNDERFLOW
`ifdef ALU_RESULT_ACC_COUNT_EN
    , input ACC_COUNT
`endif
  );

  modport slave (
    input  CEP, RSTP, USE_SIMD, S, result_SIMD_carry_out,
    output P, CARRYOUT, PATTERNDETECT, PATTERNBDETECT, OVERFLOW, UNDERFLOW
`ifdef ALU_RESULT_ACC_COUNT_EN
    , output ACC_COUNT
`endif
  );

endinterface

// File: rtl/alu_result_stage_simd_pattern_detect_lane.sv
// Masked compare of one lane against a pattern and its complement.
// A set MASK bit removes that bit from both compares.
module pattern_detect_lane #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] LANE_PATTERN = '0,
  parameter logic [WIDTH-1:0] LANE_MASK    = '0
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             match_o,
  output logic             barMatch_o
);

  assign match_o    = ((data_i ^ LANE_PATTERN) & ~LANE_MASK) == '0;
  assign barMatch_o = ((data_i ^ ~LANE_PATTERN) & ~LANE_MASK) == '0;

endmodule

// File: rtl/alu_result_stage_simd.sv
// Output register stage behind the 2x16 SIMD ALU: registers P and carries,
// detects pattern / pattern-bar per lane, derives overflow/underflow from the
// detect history and optionally auto-clears lanes on (no-)match.
// Optional feature macro: ALU_RESULT_ACC_COUNT_EN adds an 8-bit saturating
// load counter for lane0 on ACC_COUNT.
module alu_result_stage_simd
  import pirdsp_alu_pkg::*;
#(
  parameter logic [31:0] PATTERN          = 32'h0000_0000,
  parameter logic [31:0] MASK             = 32'h0000_0000,
  parameter int          AUTORESET_PATDET = AR_NONE
) (
  input logic                    clk,
  input logic                    rst_n,
  alu_result_stage_simd_if.slave bus
);

  logic                  simdMode;
  logic [LANE_COUNT-1:0] laneTrig;
  logic [LANE_COUNT-1:0] laneClear;
  logic [LANE_COUNT-1:0] laneMatch;
  logic [LANE_COUNT-1:0] laneBarMatch;

  logic [31:0]           p_d, p_q;
  logic [LANE_COUNT-1:0] carry_d, carry_q;
  logic [LANE_COUNT-1:0] pd_d, pd_q;
  logic [LANE_COUNT-1:0] pbd_d, pbd_q;
  logic [LANE_COUNT-1:0] pdPast_q, pbdPast_q;

  assign simdMode = (bus.USE_SIMD == mode_sum_8x8);

  // Decide which lanes clear this edge; in 32-bit mode bit0 holds the whole-word detect and clears both halves.
  always_comb begin
    laneTrig = '0;
    case (AUTORESET_PATDET)
      AR_NONE:    laneTrig = '0;
      AR_MATCH:   laneTrig = pd_q;
      AR_NOMATCH: laneTrig = ~pd_q;
      default:    laneTrig = '0;
    endcase
    laneClear = simdMode ? laneTrig : {LANE_COUNT{laneTrig[0]}};
  end

  // Next-state data: cleared lanes load zero (and their carry), so their detects are recomputed on zero.
  always_comb begin
    p_d     = bus.S;
    carry_d = bus.result_SIMD_carry_out & ~laneClear;
    if (laneClear[0]) p_d[LANE_WIDTH-1:0] = '0;
    if (laneClear[1]) p_d[2*LANE_WIDTH-1:LANE_WIDTH] = '0;
  end

  pattern_detect_lane #(
    .WIDTH       (LANE_WIDTH),
    .LANE_PATTERN(PATTERN[LANE_WIDTH-1:0]),
    .LANE_MASK   (MASK[LANE_WIDTH-1:0])
  ) uLane0 (
    .data_i    (p_d[LANE_WIDTH-1:0]),
    .match_o   (laneMatch[0]),
    .barMatch_o(laneBarMatch[0])
  );

  pattern_detect_lane #(
    .WIDTH       (LANE_WIDTH),
    .LANE_PATTERN(PATTERN[2*LANE_WIDTH-1:LANE_WIDTH]),
    .LANE_MASK   (MASK[2*LANE_WIDTH-1:LANE_WIDTH])
  ) uLane1 (
    .data_i    (p_d[2*LANE_WIDTH-1:LANE_WIDTH]),
    .match_o   (laneMatch[1]),
    .barMatch_o(laneBarMatch[1])
  );

  // Combine lane detects: independent in SIMD mode, one whole-word result replicated in 32-bit mode.
  always_comb begin
    pd_d  = simdMode ? laneMatch    : {LANE_COUNT{&laneMatch}};
    pbd_d = simdMode ? laneBarMatch : {LANE_COUNT{&laneBarMatch}};
  end

  // Result, carry, detect and detect-history registers; RSTP beats CEP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q       <= '0;
      carry_q   <= '0;
      pd_q      <= '0;
      pbd_q     <= '0;
      pdPast_q  <= '0;
      pbdPast_q <= '0;
    end else if (bus.RSTP) begin
      p_q       <= '0;
      carry_q   <= '0;
      pd_q      <= '0;
      pbd_q     <= '0;
      pdPast_q  <= '0;
      pbdPast_q <= '0;
    end else if (bus.CEP) begin
      p_q       <= p_d;
      carry_q   <= carry_d;
      pd_q      <= pd_d;
      pbd_q     <= pbd_d;
      pdPast_q  <= pd_q;
      pbdPast_q <= pbd_q;
    end
  end

  assign bus.P              = p_q;
  assign bus.CARRYOUT       = carry_q;
  assign bus.PATTERNDETECT  = pd_q;
  assign bus.PATTERNBDETECT = pbd_q;
  assign bus.OVERFLOW       = pdPast_q & ~pd_q & ~pbd_q;
  assign bus.UNDERFLOW      = pbdPast_q & ~pd_q & ~pbd_q;

`ifdef ALU_RESULT_ACC_COUNT_EN
  logic [7:0] accCount_d, accCount_q;

  // Lane0 load counter: restarts on a lane0 clear, otherwise counts up and sticks at 255.
  always_comb begin
    accCount_d = accCount_q;
    if (laneClear[0])              accCount_d = '0;
    else if (accCount_q != 8'hFF)  accCount_d = accCount_q + 8'd1;
  end

  // Counter register follows the same reset/RSTP/CEP priority as the data path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          accCount_q <= '0;
    else if (bus.RSTP)   accCount_q <= '0;
    else if (bus.CEP)    accCount_q <= accCount_d;
  end

  assign bus.ACC_COUNT = accCount_q;
`endif

endmodule

// File: tb/tb_alu_result_stage_simd.sv
// Scoreboard bench for alu_result_stage_simd (PATTERN 0005_0005, MASK
// 7FF0_7FF0, auto-reset on match). Also covers ACC_COUNT when
// ALU_RESULT_ACC_COUNT_EN is defined.
module tb_alu_result_stage_simd;

  localparam logic [31:0] PAT = 32'h0005_0005;
  localparam logic [31:0] MSK = 32'h7FF0_7FF0;

  typedef struct {
    logic [31:0] p;
    logic [1:0]  carry;
    logic [1:0]  pd;
    logic [1:0]  pbd;
    logic [1:0]  ov;
    logic [1:0]  un;
    logic [7:0]  acc;
  } exp_t;

  logic clk;
  logic rst_n;
  alu_result_stage_simd_if bus();

  alu_result_stage_simd #(
    .PATTERN         (PAT),
    .MASK            (MSK),
    .AUTORESET_PATDET(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checkCount = 0;
  int failCount  = 0;
  exp_t expQ[$];

  // Reference state, kept at the level of "what the spec says is registered".
  logic [31:0] mP;
  logic [1:0]  mCarry, mPd, mPbd, mPdPast, mPbdPast;
  int          mAcc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls the stimulus thread.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mP = '0; mCarry = '0; mPd = '0; mPbd = '0; mPdPast = '0; mPbdPast = '0; mAcc = 0;
  endtask

  function automatic logic [1:0] detectOf(input logic [31:0] v, input logic [31:0] pat, input bit simd);
    logic [31:0] diff;
    diff = (v ^ pat) & ~MSK;
    if (simd) return {diff[31:16] == 16'h0, diff[15:0] == 16'h0};
    return {2{diff == 32'h0}};
  endfunction

  task automatic modelStep(input bit rstp, input bit cep, input bit simd,
                           input logic [31:0] s, input logic [1:0] cin);
    bit clr0, clr1;
    logic [31:0] v;
    logic [1:0] c;
    if (rstp) begin
      modelReset();
    end else if (cep) begin
      clr0 = mPd[0];
      clr1 = simd ? mPd[1] : mPd[0];
      v = s;
      c = cin;
      if (clr0) begin v[15:0]  = 16'h0; c[0] = 1'b0; end
      if (clr1) begin v[31:16] = 16'h0; c[1] = 1'b0; end
      mPdPast  = mPd;
      mPbdPast = mPbd;
      mPd      = detectOf(v, PAT, simd);
      mPbd     = detectOf(v, ~PAT, simd);
      mP       = v;
      mCarry   = c;
      if (clr0)            mAcc = 0;
      else if (mAcc < 255) mAcc = mAcc + 1;
    end
  endtask

  function automatic exp_t modelOut();
    exp_t e;
    e.p     = mP;
    e.carry = mCarry;
    e.pd    = mPd;
    e.pbd   = mPbd;
    e.ov    = mPdPast & ~mPd & ~mPbd;
    e.un    = mPbdPast & ~mPd & ~mPbd;
    e.acc   = mAcc[7:0];
    return e;
  endfunction

  // Drive one cycle's inputs right now and queue the response due after the next rising edge.
  task automatic driveNow(input bit rstp, input bit cep, input bit simd,
                          input logic [31:0] s, input logic [1:0] cin);
    bus.RSTP = rstp;
    bus.CEP = cep;
    bus.USE_SIMD = simd;
    bus.S = s;
    bus.result_SIMD_carry_out = cin;
    modelStep(rstp, cep, simd, s, cin);
    expQ.push_back(modelOut());
  endtask

  task automatic applyStimulus(input bit rstp, input bit cep, input bit simd,
                               input logic [31:0] s, input logic [1:0] cin);
    @(negedge clk);
    #1;
    driveNow(rstp, cep, simd, s, cin);
  endtask

  // Async reset in the middle of a cycle: outputs must drop before any clock edge.
  task automatic doAsyncReset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst P", bus.P, 32'h0);
    checkOutput("async_rst CARRYOUT", {30'h0, bus.CARRYOUT}, 32'h0);
    checkOutput("async_rst PD", {30'h0, bus.PATTERNDETECT}, 32'h0);
    checkOutput("async_rst PBD", {30'h0, bus.PATTERNBDETECT}, 32'h0);
    checkOutput("async_rst OV", {30'h0, bus.OVERFLOW}, 32'h0);
    checkOutput("async_rst UN", {30'h0, bus.UNDERFLOW}, 32'h0);
`ifdef ALU_RESULT_ACC_COUNT_EN
    checkOutput("async_rst ACC", {24'h0, bus.ACC_COUNT}, 32'h0);
`endif
    modelReset();
    #1 rst_n = 1'b1;
    driveNow(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 2'b00);
  endtask

  // Lane generator biased toward match, bar-match and neither.
  function automatic logic [15:0] laneValue(input int kind);
    logic [15:0] r;
    r = 16'($urandom);
    case (kind)
      1:       return (r & 16'h7FF0) | 16'h0005;
      2:       return (r & 16'h7FF0) | 16'h800A;
      default: return r;
    endcase
  endfunction

  // Monitor: every falling edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("P", bus.P, e.p);
        checkOutput("CARRYOUT", {30'h0, bus.CARRYOUT}, {30'h0, e.carry});
        checkOutput("PATTERNDETECT", {30'h0, bus.PATTERNDETECT}, {30'h0, e.pd});
        checkOutput("PATTERNBDETECT", {30'h0, bus.PATTERNBDETECT}, {30'h0, e.pbd});
        checkOutput("OVERFLOW", {30'h0, bus.OVERFLOW}, {30'h0, e.ov});
        checkOutput("UNDERFLOW", {30'h0, bus.UNDERFLOW}, {30'h0, e.un});
`ifdef ALU_RESULT_ACC_COUNT_EN
        checkOutput("ACC_COUNT", {24'h0, bus.ACC_COUNT}, {24'h0, e.acc});
`endif
      end
    end
  end

  // Stimulus: directed sequences first, then randomized traffic, then saturation.
  initial begin
    bit simd;
    rst_n = 1'b0;
    bus.CEP = 1'b0;
    bus.RSTP = 1'b0;
    bus.USE_SIMD = 1'b0;
    bus.S = '0;
    bus.result_SIMD_carry_out = '0;
    modelReset();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] reset sequence");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 2'b11);
    doAsyncReset();

    $display("[TB] load / hold / RSTP");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h1234_5678, 2'b10);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0000, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0000, 2'b01);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0000, 2'b00);

    $display("[TB] overflow / underflow in 32-bit mode");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0003, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h800A_800A, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0003, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0000, 2'b00);

    $display("[TB] SIMD auto-reset on lane1 match");
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 32'h0005_0003, 2'b11);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0005_0005, 2'b11);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0005_0005, 2'b11);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0005_0005, 2'b11);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0005_0005, 2'b11);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0005_0005, 2'b11);

    $display("[TB] randomized traffic");
    simd = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] s;
      if ($urandom_range(0, 19) == 0) simd = ~simd;
      s = {laneValue(int'($urandom_range(0, 3))), laneValue(int'($urandom_range(0, 3)))};
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, simd,
                    s, 2'($urandom));
    end

    $display("[TB] counter saturation");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 2'b01);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 2'b00);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("scoreboard drained", expQ.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
